// File: rtl/relprime_pkg.sv
// ============================================================================
// Module   : relprime_pkg
// Brief    : Shared widths and FSM state encoding for the relprime sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package relprime_pkg;

    localparam int REL_WIDTH     = 16;
    localparam int REL_M_START   = 2;
    localparam int REL_CNT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } rel_state_t;

endpackage

`default_nettype wire

// File: rtl/relprime_gcd_core.sv
// ============================================================================
// Module   : relprime_gcd_core
// Brief    : Subtraction-based Euclid GCD datapath, one step per enabled cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module relprime_gcd_core
    import relprime_pkg::*;
#(
    parameter int WIDTH = REL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a_init,
    input  logic [WIDTH-1:0] i_b_init,
    output logic             o_b_zero,
    output logic [WIDTH-1:0] o_gcd
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    // The larger operand is always the minuend, so neither register underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= i_a_init;
            r_b <= i_b_init;
        end else if (i_step && (r_b != '0)) begin
            if (r_a > r_b) begin
                r_a <= r_a - r_b;
            end else begin
                r_b <= r_b - r_a;
            end
        end
    end

    assign o_b_zero = (r_b == '0);
    assign o_gcd    = r_a;

endmodule

`default_nettype wire

// File: rtl/relprime_sequencer.sv
// ============================================================================
// Module   : relprime_sequencer
// Brief    : Finds the smallest m >= M_START coprime to n using a GCD core.
//            Optional busy-cycle counter enabled by RELPRIME_CYCLE_COUNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module relprime_sequencer
    import relprime_pkg::*;
#(
    parameter int WIDTH   = REL_WIDTH,
    parameter int M_START = REL_M_START
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         n_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         result
`ifdef RELPRIME_CYCLE_COUNT_EN
    ,
    output logic [REL_CNT_WIDTH-1:0] cycles
`endif
);

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_m_start = WIDTH'(M_START);

    rel_state_t       r_state;
    rel_state_t       w_next_state;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic             w_load;
    logic             w_step;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_gcd;
    logic [WIDTH-1:0] w_m_next;
    logic             w_m_wrap;

    assign w_m_next = r_m + c_one;
    assign w_m_wrap = (w_m_next == '0);

    relprime_gcd_core #(
        .WIDTH (WIDTH)
    ) u_gcd_core (
        .clk      (CLK),
        .rst      (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_a_init (r_n),
        .i_b_init (r_m),
        .o_b_zero (w_b_zero),
        .o_gcd    (w_gcd)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (n_in == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                w_load       = 1'b1;
                w_next_state = RUN;
            end
            RUN: begin
                w_step = !w_b_zero;
                if (w_b_zero) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                if ((w_gcd == c_one) || w_m_wrap) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = LOAD;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Result is left untouched on a new start; it only changes at completion.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_n      <= '0;
            r_m      <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n   <= n_in;
                        r_m   <= c_m_start;
                        r_err <= 1'b0;
                        if (n_in == '0) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (w_gcd == c_one) begin
                        r_result <= r_m;
                    end else if (w_m_wrap) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_m <= w_m_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign err    = r_err;
    assign result = r_result;

`ifdef RELPRIME_CYCLE_COUNT_EN
    logic [REL_CNT_WIDTH-1:0] r_cycles;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_cycles <= '0;
            end
        end else if (r_cycles != '1) begin
            r_cycles <= r_cycles + REL_CNT_WIDTH'(1);
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_relprime_sequencer.sv
// ============================================================================
// Module   : tb_relprime_sequencer
// Brief    : Self-checking bench for relprime_sequencer against a gcd/relprime
//            reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_relprime_sequencer;

    localparam int BOUND = 60000;

    logic        CLK;
    logic        reset;
    logic        start;
    logic [15:0] n_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
`ifdef RELPRIME_CYCLE_COUNT_EN
    logic [31:0] cycles;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    relprime_sequencer dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .n_in   (n_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
`ifdef RELPRIME_CYCLE_COUNT_EN
        ,
        .cycles (cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
        int unsigned a = x;
        int unsigned b = y;
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int unsigned ref_relprime(input int unsigned n);
        int unsigned m = 2;
        if (n == 0) return 0;
        while (ref_gcd(n, m) != 1) m++;
        return m;
    endfunction

    // Busy cycles: per candidate m, one load, one per subtraction, zero-detect and check; plus done.
    function automatic int unsigned ref_busy(input int unsigned n);
        int unsigned total = 1;
        int unsigned last;
        int unsigned a;
        int unsigned b;
        if (n == 0) return 1;
        last = ref_relprime(n);
        for (int unsigned m = 2; m <= last; m++) begin
            a = n;
            b = m;
            total += 3;
            while (b != 0) begin
                if (a > b) a -= b;
                else b -= a;
                total++;
            end
        end
        return total;
    endfunction

    task automatic run_job(input int unsigned n, input string tag, input int disturb);
        int unsigned exp_r    = ref_relprime(n);
        int unsigned exp_busy = ref_busy(n);
        logic        exp_e    = (n == 0);
        int          cnt;
        start = 1'b1;
        n_in  = n[15:0];
        @(posedge CLK); #1;
        start = 1'b0;
        check($sformatf("%s.busy_on_accept", tag), {31'b0, busy}, 32'd1);
        cnt = 1;
        while (!done && cnt < BOUND) begin
            if (disturb > 0 && cnt == disturb) begin
                start = 1'b1;
                n_in  = 16'd3;
            end else if (disturb > 0 && cnt == disturb + 1) begin
                start = 1'b0;
                n_in  = 16'($urandom);
            end
            @(posedge CLK); #1;
            cnt++;
        end
        start = 1'b0;
        check($sformatf("%s.done", tag), {31'b0, done}, 32'd1);
        check($sformatf("%s.busy_cycles", tag), cnt, exp_busy);
        check($sformatf("%s.result", tag), {16'b0, result}, exp_r);
        check($sformatf("%s.err", tag), {31'b0, err}, {31'b0, exp_e});
        @(posedge CLK); #1;
        check($sformatf("%s.done_pulse", tag), {30'b0, done, busy}, 32'd0);
        check($sformatf("%s.result_held", tag), {15'b0, err, result}, {15'b0, exp_e, exp_r[15:0]});
`ifdef RELPRIME_CYCLE_COUNT_EN
        check($sformatf("%s.cycles", tag), cycles, exp_busy);
`endif
    endtask

    initial begin
        int cnt;
        bit seen_done;
        int unsigned rn;

        reset = 1'b1;
        start = 1'b0;
        n_in  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset.state", {28'b0, busy, done, err, 1'b0}, 32'd0);
        check("reset.result", {16'b0, result}, 32'd0);
`ifdef RELPRIME_CYCLE_COUNT_EN
        check("reset.cycles", cycles, 32'd0);
`endif
        reset = 1'b0;
        @(posedge CLK); #1;

        run_job(59411, "T1", 0);
        run_job(5040, "T2a", 0);
        repeat (5) @(posedge CLK);
        #1;
        check("T2.result_stable", {16'b0, result}, 32'd11);
        run_job(3, "T3", 0);
        run_job(0, "T4.n0", 0);
        @(posedge CLK); #1;
        check("T4.err_held", {31'b0, err}, 32'd1);
        run_job(1, "T4.n1", 0);

        // Second start and n_in change mid-run must not disturb the job.
        run_job(5040, "T5", 20);

        start = 1'b1;
        n_in  = 16'd5040;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (50) @(posedge CLK);
        #1;
        check("T5.busy_before_reset", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        check("T5.reset_abort", {29'b0, busy, done, err}, 32'd0);
        check("T5.reset_result", {16'b0, result}, 32'd0);
`ifdef RELPRIME_CYCLE_COUNT_EN
        check("T5.reset_cycles", cycles, 32'd0);
`endif
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("T5.no_done_after_reset", {31'b0, seen_done}, 32'd0);

        // Start held high: back-to-back runs separated by an idle cycle.
        start = 1'b1;
        n_in  = 16'd3;
        for (int r = 0; r < 3; r++) begin
            cnt = 0;
            while (!done && cnt < BOUND) begin
                @(posedge CLK); #1;
                cnt++;
            end
            check($sformatf("T6.run%0d.latency", r), cnt, 32'd7);
            check($sformatf("T6.run%0d.result", r), {16'b0, result}, 32'd2);
            @(posedge CLK); #1;
            if (r == 2) start = 1'b0;
            check($sformatf("T6.run%0d.idle_gap", r), {30'b0, busy, done}, 32'd0);
        end
        @(posedge CLK); #1;
        check("T6.stopped", {31'b0, busy}, 32'd0);

        for (int j = 0; j < 16; j++) begin
            if (j == 3) rn = 0;
            else if (j == 7) rn = 1;
            else rn = $urandom_range(2, 600);
            run_job(rn, $sformatf("rand%0d_n%0d", j, rn), 0);
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
